// File: rtl/ieee_normalize_round.sv
// ieee_normalize_round: post-add normalise and round stage for IEEE-754 binary32.
// Takes the raw sign, biased exponent and unnormalised mantissa from the adder.
// The mantissa is shifted right once on carry-out, or left one bit per cycle
// until the hidden bit is set. It is then rounded to nearest-even and packed
// into a single-precision word with status flags.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only when idle and out of reset)
//   in_sign             sign of the raw result
//   in_exp[9:0]         signed biased exponent; weight of in_mant[26]
//   in_mant[27:0]       {carry, hidden, fraction[22:0], guard, round, sticky}
//   out_valid/out_ready result handshake
//   out_result[31:0]    {sign, exp[7:0], frac[22:0]}
//   out_flags[3:0]      {overflow, underflow, inexact, zero}
module ieee_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [27:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    localparam int unsigned EXP_W  = 10;
    localparam int unsigned MANT_W = 28;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic                     sign_q;
    logic signed [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0]        mant_q;

    // Rounding datapath, evaluated from the held mantissa in ROUND
    logic                     round_up;
    logic [24:0]              m25;
    logic signed [EXP_W-1:0]  exp_r;
    logic [22:0]              frac_r;
    logic                     inexact;
    logic [31:0]              round_result;
    logic [3:0]               round_flags;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) state_next = CHECK;
            end
            CHECK: begin
                if (mant_q == '0)                       state_next = DONE;
                else if (mant_q[27] || mant_q[26])      state_next = ROUND;
                else                                    state_next = NORM;
            end
            NORM: begin
                // Underflow check precedes the shift; mant_q[25] becomes the hidden bit
                if (exp_q <= 10'sd1)   state_next = DONE;
                else if (mant_q[25])   state_next = ROUND;
            end
            ROUND: state_next = DONE;
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (state == IDLE && !rst) in_ready = 1'b1;
        if (state == DONE)         out_valid = 1'b1;
    end

    // Round to nearest-even, then range-check the final exponent
    always_comb begin
        round_up     = mant_q[2] & (mant_q[3] | mant_q[1] | mant_q[0]);
        m25          = {1'b0, mant_q[26:3]} + 25'(round_up);
        exp_r        = m25[24] ? exp_q + 10'sd1 : exp_q;
        frac_r       = m25[24] ? m25[23:1] : m25[22:0];
        inexact      = mant_q[2] | mant_q[1] | mant_q[0];
        round_result = {sign_q, exp_r[7:0], frac_r};
        round_flags  = {1'b0, 1'b0, inexact, 1'b0};
        if (exp_r >= 10'sd255) begin
            round_result = {sign_q, 8'hFF, 23'd0};
            round_flags  = 4'b1010;
        end else if (exp_r <= 10'sd0) begin
            round_result = {sign_q, 31'd0};
            round_flags  = {1'b0, 1'b1, inexact, 1'b1};
        end
    end

    // Operand capture, normalisation shifts and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        exp_q  <= in_exp;
                        mant_q <= in_mant;
                    end
                end
                CHECK: begin
                    if (mant_q == '0) begin
                        out_result <= '0;
                        out_flags  <= 4'b0001;
                    end else if (mant_q[27]) begin
                        // Dropped bit folds into sticky
                        mant_q <= {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                        exp_q  <= exp_q + 10'sd1;
                    end
                end
                NORM: begin
                    if (exp_q <= 10'sd1) begin
                        out_result <= {sign_q, 31'd0};
                        out_flags  <= 4'b0101;
                    end else begin
                        mant_q <= {mant_q[26:0], 1'b0};
                        exp_q  <= exp_q - 10'sd1;
                    end
                end
                ROUND: begin
                    out_result <= round_result;
                    out_flags  <= round_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_normalize_round.sv
// Directed-vector bench for ieee_normalize_round with a scoreboard queue and
// an independent output monitor.
module tb_ieee_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    ieee_normalize_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          tests  = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          valid_cycles = 0;
    logic        seen = 1'b0;
    logic [31:0] first_res;
    logic [3:0]  first_flags;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares each presented result against the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            valid_cycles++;
            if (!seen) begin
                seen        = 1'b1;
                first_res   = out_result;
                first_flags = out_flags;
                tests++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_valid result=%h flags=%b", out_result, out_flags);
                end else if (cyc + 1 - sb[0].acc != sb[0].lat) begin
                    errors++;
                    $display("FAIL latency got=%0d want=%0d", cyc + 1 - sb[0].acc, sb[0].lat);
                end
            end else begin
                tests++;
                if (out_result !== first_res || out_flags !== first_flags) begin
                    errors++;
                    $display("FAIL stable got=%h/%b want=%h/%b", out_result, out_flags, first_res, first_flags);
                end
            end
            tests++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_busy got=%b want=0", in_ready);
            end
            if (out_ready) begin
                if (sb.size() > 0) begin
                    tests++;
                    if (out_result !== sb[0].res) begin
                        errors++;
                        $display("FAIL result got=%h want=%h", out_result, sb[0].res);
                    end
                    tests++;
                    if (out_flags !== sb[0].flags) begin
                        errors++;
                        $display("FAIL flags got=%b want=%b", out_flags, sb[0].flags);
                    end
                    void'(sb.pop_front());
                end
                seen = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m,
                        input logic [31:0] r, input logic [3:0] f, input int lat);
        exp_t it;
        int   n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            errors++;
            $display("FAIL accept_timeout got=in_ready_low want=in_ready_high");
            in_valid = 1'b0;
            return;
        end
        it.res   = r;
        it.flags = f;
        it.lat   = lat;
        it.acc   = cyc + 1;
        sb.push_back(it);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
        end
    endtask

    initial begin
        int n;
        int vc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 1+1, normal path and right-shift normalisation
        send(1'b0, 10'd127, 28'h8000000, 32'h40000000, 4'b0000, 3);
        // 23 left shifts
        send(1'b0, 10'd127, 28'h0000008, 32'h34000000, 4'b0000, 26);
        // Ties: lsb 0 stays, lsb 1 rounds up
        send(1'b0, 10'd127, 28'h4000004, 32'h3F800000, 4'b0010, 3);
        send(1'b0, 10'd127, 28'h400000C, 32'h3F800002, 4'b0010, 3);
        // Rounding carry into overflow
        send(1'b0, 10'd254, 28'h7FFFFFC, 32'h7F800000, 4'b1010, 3);
        // Underflow flush during normalisation, sign kept
        send(1'b1, 10'd3,   28'h0000008, 32'h80000000, 4'b0101, 5);
        // Negative operand, single left shift
        send(1'b1, 10'd130, 28'h2000000, 32'hC0800000, 4'b0000, 4);
        wait_empty();

        // Zero input with downstream back-pressure
        #1 out_ready = 1'b0;
        send(1'b0, 10'd127, 28'h0000000, 32'h00000000, 4'b0001, 2);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_release_out_valid", 32'(out_valid), 32'd0);
        wait_empty();

        // Reset in the middle of normalisation abandons the operation
        send(1'b0, 10'd127, 28'h0000008, 32'h34000000, 4'b0000, 26);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        void'(sb.pop_back());
        vc = valid_cycles;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_abandon_valid", 32'(valid_cycles - vc), 32'd0);
        send(1'b0, 10'd127, 28'h8000000, 32'h40000000, 4'b0000, 3);
        wait_empty();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
